// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding, parameter defaults and clog2 helper for the uart_tx scheduler
package uart_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT_DONE = 2'd2} state_e;
  localparam int NREQ_DEF = 2;
  localparam int START_TIMEOUT_DEF = 16;
  localparam int LOCK_IDLE_MAX_DEF = 1024;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational rotate-priority pick starting at ptr and wrapping modulo N
module uart_rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    end
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx between NREQ byte producers with lock and timeouts
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NREQ          = NREQ_DEF,
  parameter int IDW           = (NREQ > 1) ? clog2(NREQ) : 1,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int LOCK_IDLE_MAX = LOCK_IDLE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [IDW-1:0]    grant_id,
  output logic              locked,
  output logic              active,
  output logic              err_timeout,
  output logic              err_lock,
  input  logic              err_clear
);
  localparam int SW = clog2(START_TIMEOUT + 1);
  localparam int LW = clog2(LOCK_IDLE_MAX + 1);
  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d, grant_q, grant_d, win;
  logic            locked_q, locked_d, tx_start_q, tx_start_d;
  logic            err_timeout_q, err_timeout_d, err_lock_q, err_lock_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [SW-1:0]   start_cnt_q, start_cnt_d;
  logic [LW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [NREQ-1:0] elig, gnt;
  logic            any, accept, idle_now, to_evt, lk_evt;
  assign elig      = locked_q ? (NREQ'(1) << grant_q) : '1;
  assign idle_now  = state_q == IDLE;
  assign accept    = reset_n && idle_now && !tx_busy && any;
  assign req_ready = accept ? gnt : '0;
  uart_rr_arbiter #(.N(NREQ), .W(IDW)) u_arb (
    .req(req_valid & elig),
    .ptr(rr_q),
    .gnt(gnt),
    .idx(win),
    .any(any)
  );
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    locked_d    = locked_q;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    start_cnt_d = start_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    to_evt      = 1'b0;
    lk_evt      = 1'b0;
    if (accept) begin
      state_d     = START;
      tx_start_d  = 1'b1;
      tx_data_d   = req_data[{win, 3'b000} +: 8];
      grant_d     = win;
      locked_d    = req_lock[win];
      rr_d        = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      start_cnt_d = '0;
      idle_cnt_d  = '0;
    end else if (idle_now && locked_q && !req_valid[grant_q]) begin
      lk_evt     = idle_cnt_q == LW'(LOCK_IDLE_MAX - 1);
      idle_cnt_d = lk_evt ? '0 : idle_cnt_q + 1'b1;
      locked_d   = !lk_evt;
    end
    if (state_q == START) begin
      to_evt      = !tx_busy && start_cnt_q == SW'(START_TIMEOUT - 1);
      start_cnt_d = (tx_busy || to_evt) ? start_cnt_q : start_cnt_q + 1'b1;
      tx_start_d  = !(tx_busy || to_evt);
      state_d     = tx_busy ? WAIT_DONE : to_evt ? IDLE : START;
    end
    if (state_q == WAIT_DONE && !tx_busy) state_d = IDLE;
    err_timeout_d = (err_timeout_q && !err_clear) || to_evt;
    err_lock_d    = (err_lock_q && !err_clear) || lk_evt;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      grant_q       <= '0;
      locked_q      <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      start_cnt_q   <= '0;
      idle_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      err_lock_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      grant_q       <= grant_d;
      locked_q      <= locked_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      start_cnt_q   <= start_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_lock_q    <= err_lock_d;
    end
  end
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign active      = state_q != IDLE;
  assign err_timeout = err_timeout_q;
  assign err_lock    = err_lock_q;
endmodule
